risc8_uart_rx: RTL and testbench
================================

// Module: risc8_uart_rx
// PURPOSE
//  IO-bus UART receiver for risc8; companion to the TX-only risc8_uart on the same bus.
//  Deserialises 8N1 frames from rx_in and buffers received bytes in a small FIFO.
//  The CPU reads the bytes over the same registered IO-bus protocol as the other peripherals.
//  rx_avail is a level interrupt/poll source.
// PARAMETERS
//  BASE         7'h30  IO address of register 0; the block decodes BASE+0..BASE+2.
//  DEFAULT_DIV  8'd11  Reset value of baud_div; 12 clk/bit.
//  FIFO_LOG2    2      log2 of FIFO depth; the default depth is 4 bytes.
// PORTS
//  clk       in   1  Clock.
//  reset     in   1  Synchronous, active-high reset.
//  ren       in   1  IO read strobe.
//  wen       in   1  IO write strobe.
//  addr      in   7  IO address.
//  wdata     in   8  IO write data.
//  rdata     out  8  IO read data, registered.
//  valid     out  1  One-cycle read acknowledge for a decoded address.
//  rx_in     in   1  Serial line; idle high; asynchronous.
//  rx_avail  out  1  High while the FIFO is non-empty.
// BEHAVIOUR
//  Reset (clk, reset: synchronous, active-high):
//   rdata=0, valid=0, baud_div=DEFAULT_DIV, FIFO empty, sticky flags=0.
//   FSM=IDLE, synchroniser flops=1. A reset mid-frame discards the partial byte.
//  Registers:
//   BASE+0 baud div: R/W. Bit period = baud_div+1 clk. Written value is used from the next counter reload.
//   BASE+1 status: R = {4'b0, frame_err, overrun, full, avail}.
//    W: writing 1 to bit2 clears overrun; writing 1 to bit3 clears frame_err. Other bits are ignored.
//   BASE+2 data: R pops the FIFO head. If the FIFO is empty: rdata=8'h00, valid=1, no state change. W is ignored.
//  Bus timing:
//   ren at a decoded addr in cycle N -> rdata and valid=1 in cycle N+1; valid=0 otherwise.
//   rdata holds its last value when not reading. Undecoded addresses produce no valid.
//  Input: rx_in passes through a 2-flop synchroniser; the FSM sees only the synchronised rxs.
//  Bit timing: 8-bit down-counter cnt; a tick occurs when cnt==0, which then reloads baud_div; otherwise cnt decrements.
//  FSM:
//   IDLE: rxs==0 -> cnt=baud_div>>1, go to START (mid-bit alignment).
//   START: on tick, if rxs==0 -> bitcnt=0, go to DATA; else -> IDLE (glitch rejected).
//   DATA: on tick, shift rxs into sr LSB-first (sr={rxs,sr[7:1]}). After the 8th bit -> STOP.
//   STOP: on tick, if rxs==1 -> push sr, go to IDLE. If rxs==0 -> frame_err=1, drop the byte, go to BREAK.
//   BREAK: wait for rxs==1 -> IDLE. A held-low line never produces bytes.
//  FIFO: 2^FIFO_LOG2 entries; read/write pointers are FIFO_LOG2+1 bits wide; full/empty are decided by the MSB compare.
//   Push when full with no pop in the same cycle -> byte dropped, overrun=1, FIFO contents unchanged.
//   Push and pop in the same cycle: both take effect. When full, the pop frees the slot and the push is accepted.
//   Pointers wrap modulo 2^(FIFO_LOG2+1).
//  Sticky flags: an HW set and a SW clear in the same cycle -> the flag stays set.
//  rx_avail = !empty, combinational from the registered pointers.
//  Latency: a byte is pushed 1 clk after the mid-stop-bit tick. avail rises the next cycle.
// TESTING
//  1. baud_div=3, send 0xA5 -> status read=8'h01, rx_avail=1. Data read=8'hA5. Status read=8'h00.
//  2. Send 0x01..0x05 with no reads -> status=8'h07.
//     Data reads return 01,02,03,04, then 00 on the empty read; status=8'h04.
//  3. Send 0x3C with the stop bit held low -> status=8'h08, FIFO empty, no byte until the line returns high.
//     Write 8'h08 to BASE+1 -> status=8'h00.
//  4. rx_in pulsed low for 1 clk with baud_div=3 -> START rejects it. No byte, status=8'h00.
//  5. FIFO full, issue a data read coincident with the 5th byte's push -> overrun=0.
//     Subsequent reads return 02,03,04,05.
//  6. Reset asserted during DATA of 0x55 -> FIFO empty, baud_div=11, and a following 0x81 is received correctly.
//     ren on addr BASE+3 -> valid stays 0.

Source files
------------

// File: rtl/risc8_uart_rx.sv
// risc8_uart_rx
//   IO-bus UART receiver for risc8. Deserialises 8N1 frames arriving on rx_in
//   and queues the received bytes in a small FIFO. The CPU reads them over the
//   registered IO-bus protocol shared with the other risc8 peripherals.
//
//   Register map (relative to BASE):
//     +0 baud_div  R/W  bit period = baud_div+1 clk
//     +1 status    R    {4'b0, frame_err, overrun, full, avail}
//                  W    bit2=1 clears overrun, bit3=1 clears frame_err
//     +2 data      R    pops FIFO head (8'h00 when empty, no state change)
//
// Ports
//   clk, reset   clock; synchronous active-high reset
//   ren, wen     IO read / write strobes
//   addr, wdata  IO address and write data
//   rdata, valid registered read data and one-cycle read acknowledge
//   rx_in        asynchronous serial line, idle high
//   rx_avail     high while the FIFO holds at least one byte
module risc8_uart_rx #(
  parameter logic [6:0] BASE        = 7'h30,
  parameter logic [7:0] DEFAULT_DIV = 8'd11,
  parameter int         FIFO_LOG2   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ren,
  input  logic       wen,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       valid,
  input  logic       rx_in,
  output logic       rx_avail
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int PW    = FIFO_LOG2 + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state_q, state_d;
  logic            rx_s1_q, rx_s1_d;
  logic            rx_s2_q, rx_s2_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      sr_q, sr_d;
  logic            push_q, push_d;
  logic [7:0]      baud_div_q, baud_div_d;
  logic            overrun_q, overrun_d;
  logic            frame_err_q, frame_err_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];
  logic [7:0]      rdata_q, rdata_d;
  logic            valid_q, valid_d;

  logic rxs, tick, frame_set;
  logic sel_div, sel_stat, sel_data;
  logic empty, full, pop, push_acc, overrun_set, clr_ovr, clr_fe;
  logic [7:0] status;

  assign sel_div  = (addr == BASE);
  assign sel_stat = (addr == BASE + 7'd1);
  assign sel_data = (addr == BASE + 7'd2);

  // Full when the pointers address the same slot but differ in wrap bit.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[FIFO_LOG2-1:0] == rd_ptr_q[FIFO_LOG2-1:0]);

  assign status   = {4'b0, frame_err_q, overrun_q, full, !empty};
  assign rx_avail = !empty;
  assign rdata    = rdata_q;
  assign valid    = valid_q;

  // A pop frees a slot in the same cycle, so a push into a full FIFO
  // coinciding with a pop is accepted rather than counted as an overrun.
  assign pop         = ren && sel_data && !empty;
  assign push_acc    = push_q && (!full || pop);
  assign overrun_set = push_q && full && !pop;
  assign clr_ovr     = wen && sel_stat && wdata[2];
  assign clr_fe      = wen && sel_stat && wdata[3];

  // Receive FSM and bit timer
  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    sr_d      = sr_q;
    push_d    = 1'b0;
    frame_set = 1'b0;
    rx_s1_d   = rx_in;
    rx_s2_d   = rx_s1_q;
    rxs       = rx_s2_q;
    tick      = (cnt_q == 8'd0);
    cnt_d     = tick ? baud_div_q : cnt_q - 8'd1;

    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          // Half-period load lands subsequent ticks mid-bit.
          cnt_d   = baud_div_q >> 1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (!rxs) begin
            bitcnt_d = 3'd0;
            state_d  = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          sr_d     = {rxs, sr_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (rxs) begin
            push_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO, registers and bus interface
  always_comb begin
    mem_d = mem_q;
    if (push_acc) mem_d[wr_ptr_q[FIFO_LOG2-1:0]] = sr_q;
    wr_ptr_d = wr_ptr_q + PW'(push_acc);
    rd_ptr_d = rd_ptr_q + PW'(pop);

    baud_div_d = baud_div_q;
    if (wen && sel_div) baud_div_d = wdata;

    // Hardware set wins over a simultaneous software clear.
    overrun_d   = (overrun_q && !clr_ovr) || overrun_set;
    frame_err_d = (frame_err_q && !clr_fe) || frame_set;

    valid_d = ren && (sel_div || sel_stat || sel_data);
    rdata_d = rdata_q;
    if (ren) begin
      if (sel_div)       rdata_d = baud_div_q;
      else if (sel_stat) rdata_d = status;
      else if (sel_data) rdata_d = empty ? 8'h00 : mem_q[rd_ptr_q[FIFO_LOG2-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      cnt_q       <= 8'd0;
      bitcnt_q    <= 3'd0;
      sr_q        <= 8'd0;
      push_q      <= 1'b0;
      baud_div_q  <= DEFAULT_DIV;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rdata_q     <= 8'd0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_s1_q     <= rx_s1_d;
      rx_s2_q     <= rx_s2_d;
      cnt_q       <= cnt_d;
      bitcnt_q    <= bitcnt_d;
      sr_q        <= sr_d;
      push_q      <= push_d;
      baud_div_q  <= baud_div_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rdata_q     <= rdata_d;
      valid_q     <= valid_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_risc8_uart_rx.sv
module tb_risc8_uart_rx;

  localparam logic [6:0] BASE = 7'h30;

  logic       clk = 1'b0;
  logic       reset;
  logic       ren, wen;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       valid;
  logic       rx_in;
  logic       rx_avail;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard doubles as the reference FIFO (depth 4).
  logic [7:0] sb[$];
  logic       exp_ovr = 1'b0;
  logic       exp_fe  = 1'b0;

  risc8_uart_rx dut (
    .clk      (clk),
    .reset    (reset),
    .ren      (ren),
    .wen      (wen),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .valid    (valid),
    .rx_in    (rx_in),
    .rx_avail (rx_avail)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_status();
    return {4'b0, exp_fe, exp_ovr, (sb.size() == 4), (sb.size() != 0)};
  endfunction

  task automatic bus_read(input logic [6:0] a, output logic [7:0] d, output logic v);
    @(negedge clk);
    addr = a;
    ren  = 1'b1;
    @(negedge clk);
    ren = 1'b0;
    d   = rdata;
    v   = valid;
  endtask

  task automatic bus_write(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    wen   = 1'b1;
    @(negedge clk);
    wen = 1'b0;
  endtask

  // Drives one 8N1 frame; a good stop bit is followed by two idle bit periods.
  task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int bitp);
    logic [9:0] frame;
    frame = {stop_ok, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rx_in = frame[i];
      repeat (bitp) @(negedge clk);
    end
    if (stop_ok) begin
      if (sb.size() < 4) sb.push_back(b);
      else exp_ovr = 1'b1;
      repeat (2 * bitp) @(negedge clk);
    end else begin
      exp_fe = 1'b1;
    end
  endtask

  task automatic check_status(input string name);
    logic [7:0] d;
    logic       v;
    logic [7:0] e;
    e = exp_status();
    bus_read(BASE + 7'd1, d, v);
    n_checks++;
    if (d !== e || v !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: status got %h valid %b, expected %h valid 1", name, d, v, e);
    end
  endtask

  task automatic check_data(input string name);
    logic [7:0] d;
    logic       v;
    logic [7:0] e;
    e = (sb.size() != 0) ? sb.pop_front() : 8'h00;
    bus_read(BASE + 7'd2, d, v);
    n_checks++;
    if (d !== e || v !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: data got %h valid %b, expected %h valid 1", name, d, v, e);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic       v;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rdata !== 8'h00 || valid !== 1'b0 || rx_avail !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdata %h valid %b avail %b, expected 00 0 0", rdata, valid, rx_avail);
    end
    bus_read(BASE, d, v);
    n_checks++;
    if (d !== 8'h0B || v !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_baud: got %h valid %b, expected 0b valid 1", d, v);
    end
    check_status("reset_status");
  endtask

  task automatic test_single_byte();
    bus_write(BASE, 8'd3);
    send_byte(8'hA5, 1'b1, 4);
    check_status("single_status_avail");
    n_checks++;
    if (rx_avail !== 1'b1) begin
      n_fail++;
      $display("FAIL single_rx_avail: got %b, expected 1", rx_avail);
    end
    check_data("single_data");
    check_status("single_status_empty");
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, 4);
    check_status("overrun_status_full");
    for (int i = 0; i < 5; i++) check_data("overrun_drain");
    check_status("overrun_status_after");
  endtask

  task automatic test_frame_error();
    send_byte(8'h3C, 1'b0, 4);
    repeat (8) @(negedge clk);
    check_status("ferr_status_low");
    repeat (12) @(negedge clk);
    n_checks++;
    if (rx_avail !== 1'b0) begin
      n_fail++;
      $display("FAIL ferr_break_no_byte: avail %b, expected 0", rx_avail);
    end
    rx_in = 1'b1;
    repeat (12) @(negedge clk);
    check_status("ferr_status_released");
    bus_write(BASE + 7'd1, 8'h08);
    exp_fe = 1'b0;
    check_status("ferr_cleared");
  endtask

  task automatic test_glitch();
    @(negedge clk);
    rx_in = 1'b0;
    @(negedge clk);
    rx_in = 1'b1;
    repeat (60) @(negedge clk);
    check_status("glitch_status");
    n_checks++;
    if (rx_avail !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_avail: got %b, expected 0", rx_avail);
    end
  endtask

  task automatic test_full_push_pop();
    logic [9:0] frame;
    logic [7:0] e;
    bus_write(BASE + 7'd1, 8'h04);
    exp_ovr = 1'b0;
    check_status("fpp_ovr_cleared");
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1, 4);
    check_status("fpp_full");
    // Frame starts at negedge n0; the push lands at the 42nd posedge after it.
    frame = {1'b1, 8'h05, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rx_in = frame[i];
      repeat (4) @(negedge clk);
    end
    @(negedge clk);
    addr = BASE + 7'd2;
    ren  = 1'b1;
    @(negedge clk);
    ren = 1'b0;
    e = sb.pop_front();
    sb.push_back(8'h05);
    n_checks++;
    if (rdata !== e || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL fpp_coincident_read: got %h valid %b, expected %h valid 1", rdata, valid, e);
    end
    repeat (4) @(negedge clk);
    check_status("fpp_no_overrun");
    for (int i = 0; i < 4; i++) check_data("fpp_drain");
    check_status("fpp_empty");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    logic       v;
    logic [3:0] part;
    part = 4'b1010;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_in = part[i];
      repeat (4) @(negedge clk);
    end
    reset = 1'b1;
    rx_in = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    exp_ovr = 1'b0;
    exp_fe  = 1'b0;
    repeat (20) @(negedge clk);
    bus_read(BASE, d, v);
    n_checks++;
    if (d !== 8'h0B || v !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_baud: got %h valid %b, expected 0b valid 1", d, v);
    end
    check_status("midreset_status");
    send_byte(8'h81, 1'b1, 12);
    check_status("midreset_status_avail");
    check_data("midreset_data");
    bus_read(BASE + 7'd3, d, v);
    n_checks++;
    if (v !== 1'b0) begin
      n_fail++;
      $display("FAIL undecoded_valid: got %b, expected 0", v);
    end
  endtask

  initial begin
    reset = 1'b1;
    ren   = 1'b0;
    wen   = 1'b0;
    addr  = 7'h00;
    wdata = 8'h00;
    rx_in = 1'b1;
    test_reset();
    test_single_byte();
    test_overrun();
    test_frame_error();
    test_glitch();
    test_full_push_pop();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
